// File: rtl/tile_match_game_if.sv
// Key input and board status bundle between the mode FSM and the in-game controller.
interface tile_match_game_if;
    logic        ingameOn;
    logic [7:0]  ps2_key_data;
    logic        ps2_key_pressed;
    logic        gameOver;
    logic [3:0]  cursor_pos;
    logic [15:0] revealed_mask;
    logic [15:0] matched_mask;
    logic [3:0]  pairs_found;
    logic [7:0]  move_count;
    logic [2:0]  currentGameState;

    // Mode FSM / keyboard side: drives keys, observes board status.
    modport master (
        output ingameOn, ps2_key_data, ps2_key_pressed,
        input  gameOver, cursor_pos, revealed_mask, matched_mask,
               pairs_found, move_count, currentGameState
    );

    // Game controller side.
    modport slave (
        input  ingameOn, ps2_key_data, ps2_key_pressed,
        output gameOver, cursor_pos, revealed_mask, matched_mask,
               pairs_found, move_count, currentGameState
    );
endinterface

// File: rtl/tile_match_game_fsm.sv
// In-game controller for a 4x4 tile-matching board: cursor movement, tile
// flipping, pair checking, timed reveal of mismatches and game completion.
module tile_match_game_fsm #(
    parameter int unsigned SHOW_CYCLES  = 25000000,
    parameter logic [47:0] BOARD_LAYOUT = 48'o7654321076543210
) (
    input  logic               CLOCK_50,
    input  logic               userquit,
    tile_match_game_if.slave   bus
);

    localparam int unsigned TIMER_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_UP    = 8'h1D;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;
    localparam logic [7:0] KEY_SEL   = 8'h29;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK1 = 3'd1,
        PICK2 = 3'd2,
        CHECK = 3'd3,
        SHOW  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [3:0]           cursor, cursor_n;
    logic [15:0]          revealed, revealed_n;
    logic [15:0]          matched, matched_n;
    logic [3:0]           pairs, pairs_n;
    logic [7:0]           moves, moves_n;
    logic                 brk, brk_n;
    logic [3:0]           first_idx, first_idx_n;
    logic [3:0]           second_idx, second_idx_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic                 game_over, game_over_n;
    logic                 make_c;

    // Face value of a tile from the packed 3-bit-per-tile layout.
    function automatic logic [2:0] tile_val(input logic [3:0] idx);
        return BOARD_LAYOUT[3*idx +: 3];
    endfunction

    // State and board registers.
    always_ff @(posedge CLOCK_50 or posedge userquit) begin
        if (userquit) begin
            state      <= IDLE;
            cursor     <= '0;
            revealed   <= '0;
            matched    <= '0;
            pairs      <= '0;
            moves      <= '0;
            brk        <= 1'b0;
            first_idx  <= '0;
            second_idx <= '0;
            timer      <= '0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            cursor     <= cursor_n;
            revealed   <= revealed_n;
            matched    <= matched_n;
            pairs      <= pairs_n;
            moves      <= moves_n;
            brk        <= brk_n;
            first_idx  <= first_idx_n;
            second_idx <= second_idx_n;
            timer      <= timer_n;
            game_over  <= game_over_n;
        end
    end

    // Key decode, next-state and next-board computation.
    always_comb begin
        state_n      = state;
        cursor_n     = cursor;
        revealed_n   = revealed;
        matched_n    = matched;
        pairs_n      = pairs;
        moves_n      = moves;
        brk_n        = brk;
        first_idx_n  = first_idx;
        second_idx_n = second_idx;
        timer_n      = timer;
        make_c       = 1'b0;

        // The byte after a break prefix is a key release and is swallowed.
        if (bus.ps2_key_pressed) begin
            if (brk) begin
                brk_n = 1'b0;
            end else if (bus.ps2_key_data == KEY_BREAK) begin
                brk_n = 1'b1;
            end else if (bus.ps2_key_data != KEY_EXT) begin
                make_c = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                cursor_n     = '0;
                revealed_n   = '0;
                matched_n    = '0;
                pairs_n      = '0;
                moves_n      = '0;
                brk_n        = 1'b0;
                first_idx_n  = '0;
                second_idx_n = '0;
                timer_n      = '0;
                if (bus.ingameOn) state_n = PICK1;
            end
            PICK1, PICK2: begin
                if (make_c) begin
                    case (bus.ps2_key_data)
                        KEY_UP:    if (cursor[3:2] != 2'd0) cursor_n = cursor - 4'd4;
                        KEY_DOWN:  if (cursor[3:2] != 2'd3) cursor_n = cursor + 4'd4;
                        KEY_LEFT:  if (cursor[1:0] != 2'd0) cursor_n = cursor - 4'd1;
                        KEY_RIGHT: if (cursor[1:0] != 2'd3) cursor_n = cursor + 4'd1;
                        KEY_SEL: begin
                            if (state == PICK1) begin
                                if (!matched[cursor]) begin
                                    revealed_n[cursor] = 1'b1;
                                    first_idx_n        = cursor;
                                    state_n            = PICK2;
                                end
                            end else if (cursor != first_idx && !matched[cursor]) begin
                                revealed_n[cursor] = 1'b1;
                                second_idx_n       = cursor;
                                if (moves != 8'hFF) moves_n = moves + 8'd1;
                                state_n            = CHECK;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CHECK: begin
                if (tile_val(first_idx) == tile_val(second_idx)) begin
                    matched_n[first_idx]   = 1'b1;
                    matched_n[second_idx]  = 1'b1;
                    revealed_n[first_idx]  = 1'b0;
                    revealed_n[second_idx] = 1'b0;
                    pairs_n                = pairs + 4'd1;
                    state_n                = (pairs == 4'd7) ? DONE : PICK1;
                end else begin
                    timer_n = TIMER_W'(SHOW_CYCLES - 1);
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (timer == '0) begin
                    revealed_n[first_idx]  = 1'b0;
                    revealed_n[second_idx] = 1'b0;
                    state_n                = PICK1;
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
            DONE: ;
            default: state_n = IDLE;
        endcase

        // Leaving the game from any active state wipes the board.
        if (state != IDLE && !bus.ingameOn) begin
            state_n      = IDLE;
            cursor_n     = '0;
            revealed_n   = '0;
            matched_n    = '0;
            pairs_n      = '0;
            moves_n      = '0;
            brk_n        = 1'b0;
            first_idx_n  = '0;
            second_idx_n = '0;
            timer_n      = '0;
        end

        game_over_n = (state_n == DONE);
    end

    assign bus.gameOver         = game_over;
    assign bus.cursor_pos       = cursor;
    assign bus.revealed_mask    = revealed;
    assign bus.matched_mask     = matched;
    assign bus.pairs_found      = pairs;
    assign bus.move_count       = moves;
    assign bus.currentGameState = state;

endmodule

// File: tb/tb_tile_match_game_fsm.sv
// Self-checking bench for tile_match_game_fsm: directed test-plan scenarios
// followed by randomized key traffic, all compared to a game-level model.
module tb_tile_match_game_fsm;

    localparam int unsigned SHOW    = 4;
    localparam logic [47:0] LAYOUT  = 48'o7654321076543210;

    localparam logic [7:0] KW = 8'h1D, KS = 8'h1B, KA = 8'h1C, KD = 8'h23;
    localparam logic [7:0] KSP = 8'h29, KBRK = 8'hF0, KEXT = 8'hE0;

    logic clk;
    logic rst;

    tile_match_game_if bus ();

    tile_match_game_fsm #(
        .SHOW_CYCLES (SHOW),
        .BOARD_LAYOUT(LAYOUT)
    ) dut (
        .CLOCK_50(clk),
        .userquit(rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Game-level reference model (phase numbers are the published state codes).
    int m_phase;
    int m_row, m_col;
    bit m_up[16];
    bit m_got[16];
    int m_val[16];
    int m_pairs, m_moves, m_first, m_second, m_show_left;
    bit m_brk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mask_of(input bit a[16]);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = a[i];
        return m;
    endfunction

    task automatic model_clear();
        m_phase = 0; m_row = 0; m_col = 0;
        m_pairs = 0; m_moves = 0; m_first = 0; m_second = 0; m_show_left = 0;
        m_brk = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_up[i]  = 1'b0;
            m_got[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit ing, input bit pr, input logic [7:0] k);
        bit make;
        int idx;
        if (m_phase != 0 && !ing) begin
            model_clear();
            return;
        end
        if (m_phase == 0) begin
            model_clear();
            if (ing) m_phase = 1;
            return;
        end
        make = 1'b0;
        if (pr) begin
            if (m_brk) m_brk = 1'b0;
            else if (k == KBRK) m_brk = 1'b1;
            else if (k != KEXT) make = 1'b1;
        end
        idx = m_row * 4 + m_col;
        case (m_phase)
            1, 2: if (make) begin
                if (k == KW && m_row > 0) m_row--;
                else if (k == KS && m_row < 3) m_row++;
                else if (k == KA && m_col > 0) m_col--;
                else if (k == KD && m_col < 3) m_col++;
                else if (k == KSP) begin
                    if (m_phase == 1 && !m_got[idx]) begin
                        m_up[idx] = 1'b1; m_first = idx; m_phase = 2;
                    end else if (m_phase == 2 && idx != m_first && !m_got[idx]) begin
                        m_up[idx] = 1'b1; m_second = idx;
                        if (m_moves < 255) m_moves++;
                        m_phase = 3;
                    end
                end
            end
            3: begin
                if (m_val[m_first] == m_val[m_second]) begin
                    m_got[m_first] = 1'b1; m_got[m_second] = 1'b1;
                    m_up[m_first]  = 1'b0; m_up[m_second]  = 1'b0;
                    m_pairs++;
                    m_phase = (m_pairs == 8) ? 5 : 1;
                end else begin
                    m_show_left = SHOW;
                    m_phase = 4;
                end
            end
            4: begin
                m_show_left--;
                if (m_show_left == 0) begin
                    m_up[m_first] = 1'b0; m_up[m_second] = 1'b0;
                    m_phase = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".state"},    32'(bus.currentGameState), 32'(m_phase));
        check({tag, ".cursor"},   32'(bus.cursor_pos),       32'(m_row * 4 + m_col));
        check({tag, ".revealed"}, 32'(bus.revealed_mask),    32'(mask_of(m_up)));
        check({tag, ".matched"},  32'(bus.matched_mask),     32'(mask_of(m_got)));
        check({tag, ".pairs"},    32'(bus.pairs_found),      32'(m_pairs));
        check({tag, ".moves"},    32'(bus.move_count),       32'(m_moves));
        check({tag, ".gameover"}, 32'(bus.gameOver),         32'(m_phase == 5));
    endtask

    task automatic step(input string tag, input bit ing, input bit pr, input logic [7:0] k);
        bus.ingameOn        = ing;
        bus.ps2_key_pressed = pr;
        bus.ps2_key_data    = k;
        @(posedge clk);
        #1;
        model_step(ing, pr, k);
        compare_all(tag);
        bus.ps2_key_pressed = 1'b0;
    endtask

    task automatic key(input logic [7:0] k);
        step("key", 1'b1, 1'b1, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b1, 1'b0, 8'h00);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        compare_all("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic goto_tile(input int t);
        int guard;
        guard = 0;
        while (m_row > t / 4 && guard < 8) begin key(KW); guard++; end
        while (m_row < t / 4 && guard < 8) begin key(KS); guard++; end
        while (m_col > t % 4 && guard < 8) begin key(KA); guard++; end
        while (m_col < t % 4 && guard < 8) begin key(KD); guard++; end
    endtask

    initial begin
        logic [7:0] pool [8];
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.ingameOn        = 1'b0;
        bus.ps2_key_pressed = 1'b0;
        bus.ps2_key_data    = 8'h00;
        for (int i = 0; i < 16; i++) m_val[i] = int'((LAYOUT >> (3 * i)) & 48'd7);
        model_clear();

        // Reset and start
        @(posedge clk);
        apply_reset();
        check("rst_state", 32'(bus.currentGameState), 32'd0);
        step("start", 1'b1, 1'b0, 8'h00);
        check("start_state", 32'(bus.currentGameState), 32'd1);

        // Movement and edge clamping
        key(KD); key(KD); key(KD);
        check("right3", 32'(bus.cursor_pos), 32'd3);
        key(KD);
        check("clamp_right", 32'(bus.cursor_pos), 32'd3);
        key(KS);
        check("down", 32'(bus.cursor_pos), 32'd7);
        key(KBRK); key(KS);
        check("break_ignored", 32'(bus.cursor_pos), 32'd7);
        key(KEXT); key(KW);
        check("ext_up", 32'(bus.cursor_pos), 32'd3);
        key(KA); key(KA); key(KW);
        check("clamp_up", 32'(bus.cursor_pos), 32'd1);

        // Matching pair 0/8
        goto_tile(0); key(KSP);
        goto_tile(8); key(KSP);
        check("match_moves", 32'(bus.move_count), 32'd1);
        check("match_check", 32'(bus.currentGameState), 32'd3);
        idle(1);
        check("match_mask", 32'(bus.matched_mask), 32'h0101);
        check("match_pairs", 32'(bus.pairs_found), 32'd1);

        // Mismatch 1/2 with a move attempted during the reveal
        goto_tile(1); key(KSP);
        key(KD); key(KSP);
        idle(1);
        check("show_state", 32'(bus.currentGameState), 32'd4);
        check("show_mask", 32'(bus.revealed_mask), 32'h0006);
        key(KD);
        check("show_no_move", 32'(bus.cursor_pos), 32'd2);
        idle(SHOW);
        check("show_over", 32'(bus.revealed_mask), 32'h0000);

        // Illegal selects
        goto_tile(0); key(KSP);
        check("sel_matched", 32'(bus.currentGameState), 32'd1);
        goto_tile(3); key(KSP); key(KSP);
        check("sel_same", 32'(bus.currentGameState), 32'd2);
        check("sel_same_moves", 32'(bus.move_count), 32'd2);
        goto_tile(4); key(KSP);
        idle(SHOW + 2);

        // Remaining seven pairs
        for (int v = 1; v < 8; v++) begin
            goto_tile(v); key(KSP);
            goto_tile(v + 8); key(KSP);
            idle(1);
        end
        check("done_over", 32'(bus.gameOver), 32'd1);
        check("done_pairs", 32'(bus.pairs_found), 32'd8);
        check("done_mask", 32'(bus.matched_mask), 32'hFFFF);
        key(KA); key(KSP); key(KW);
        check("done_hold", 32'(bus.currentGameState), 32'd5);
        step("quit", 1'b0, 1'b0, 8'h00);
        check("quit_over", 32'(bus.gameOver), 32'd0);
        check("quit_mask", 32'(bus.matched_mask), 32'h0000);

        // Randomized key traffic
        pool = '{KW, KS, KA, KD, KSP, KBRK, KEXT, 8'h00};
        for (int c = 0; c < 4000; c++) begin
            logic [7:0] k;
            bit ing, pr;
            if ($urandom_range(0, 799) == 0) apply_reset();
            k = pool[$urandom_range(0, 7)];
            if (k == 8'h00) k = 8'($urandom);
            if ($urandom_range(0, 2) == 0) k = KSP;
            ing = ($urandom_range(0, 149) != 0);
            pr  = ($urandom_range(0, 1) == 1);
            step("rand", ing, pr, k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tile_match_game_fsm.md
Name: tile_match_game_fsm

Overview:
- In-game controller for the tile-matching game on a 4x4 board (16 tiles, 8 pairs).
- Runs while the mode FSM asserts ingameOn; consumes PS/2 scancode bytes to move a cursor and flip tiles.
- Tracks revealed and matched tiles; raises gameOver to the mode FSM when all 8 pairs are matched.
- Its outputs feed the VGA board renderer and the HEX score display.

Parameters:
- SHOW_CYCLES, 25000000: cycles a mismatched pair stays revealed (0.5 s at 50 MHz); must be at least 1.
- BOARD_LAYOUT, 48'o7654321076543210: tile i value = BOARD_LAYOUT[3*i+2:3*i]; must hold each value 0..7 exactly twice (not checked).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- userquit  in  1  asynchronous active-high reset
- ingameOn  in  1  high while the mode FSM is in its in-game mode
- ps2_key_data  in  8  received PS/2 byte
- ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid this cycle
- gameOver  out  1  high in DONE
- cursor_pos  out  4  cursor tile index, row*4+col
- revealed_mask  out  16  bit i = tile i face-up, not yet matched
- matched_mask  out  16  bit i = tile i permanently matched
- pairs_found  out  4  0..8
- move_count  out  8  completed two-tile attempts, saturates at 255
- currentGameState  out  3  state code, debug only

Behaviour:
- Reset (userquit high, asynchronous): state IDLE, all outputs 0, break flag 0, first_idx 0, second_idx 0, show timer 0. Reset overrides everything, including mid-SHOW.
- States and codes: IDLE=0, PICK1=1, PICK2=2, CHECK=3, SHOW=4, DONE=5.
- Any state other than IDLE with ingameOn low goes to IDLE next edge. IDLE clears all outputs to 0.
- IDLE to PICK1 when ingameOn is high. On entry, cursor, masks, counters and break flag are all 0.
- Key decode, only on cycles where ps2_key_pressed is 1:
  - Byte 0xF0 sets the break flag.
  - The next strobed byte clears the flag and is ignored.
  - 0xE0 is ignored and leaves the break flag unchanged.
  - The break flag updates in every state, including CHECK, SHOW and DONE.
- Make codes (acted on only in PICK1 and PICK2; dropped in all other states):
  - W=0x1D: up, if row>0
  - S=0x1B: down, if row<3
  - A=0x1C: left, if col>0
  - D=0x23: right, if col<3
  - Space=0x29: select
  - Moves clamp at the board edge; there is no wrap.
- Select in PICK1:
  - If matched_mask[cursor] is set: ignored.
  - Otherwise: set revealed_mask[cursor], first_idx<=cursor, go to PICK2.
- Select in PICK2:
  - If cursor==first_idx or the tile is matched: ignored.
  - Otherwise: set revealed_mask[cursor], second_idx<=cursor, move_count+1 (saturating), go to CHECK.
- CHECK, exactly 1 cycle:
  - Values equal:
    - Set matched bits for both tiles and clear their revealed bits.
    - Increment pairs_found.
    - If the new pairs_found is 8, go to DONE; otherwise go to PICK1.
  - Values unequal: load timer with SHOW_CYCLES-1 and go to SHOW.
- SHOW:
  - The timer decrements each cycle.
  - On the cycle the timer reaches 0, clear both revealed bits and go to PICK1.
  - Both tiles stay revealed for exactly SHOW_CYCLES cycles.
- DONE: gameOver=1, held until ingameOn falls or reset.
- Latency: every output changes on the edge after the strobe or state that causes it (registered outputs).

Test Plan:
- Reset and start: userquit pulse mid-cycle -> all outputs 0 immediately. Then ingameOn=1 -> currentGameState=1 after one edge, cursor_pos=0.
- Movement: D,D,D -> cursor 3; D again -> stays 3 (clamp); S -> 7; F0,1B -> cursor stays 7 (break byte ignored); W from cursor 1 -> stays 1.
- Match: select tile 0, S,S to tile 8, select -> move_count=1, state CHECK. Next edge -> matched_mask=0x0101, revealed_mask=0, pairs_found=1, state PICK1.
- Mismatch (SHOW_CYCLES=4): select tile 1, D to tile 2, select -> revealed_mask=0x0006 for 4 SHOW cycles, then 0. matched_mask unchanged. A D strobe during SHOW -> cursor unchanged.
- Illegal selects: select tile 0 when it is already matched -> ignored. Select tile 3, then select tile 3 again -> stays PICK2, move_count unchanged.
- Full game: match all 8 pairs -> gameOver=1 one edge after the 8th CHECK, pairs_found=8, matched_mask=0xFFFF. Keys then ignored. ingameOn=0 -> everything 0 next edge.
